vproc_mem_arb_model: RTL

//  Parametrised multi-requester memory model for vproc/mmu system benches and FPGA bring-up.
//  - NUM_PORTS requesters on the vproc mem interface (req/addr/we/be/wdata -> gnt/rvalid/err/rdata).
//  - Round-robin arbiter feeds one single-ported word array.
//  - Fixed-latency response pipeline tags each response with the originating port.
//  - Generalises the single-port, single-latency memory model: per-port grant, ordered tagged

---
 rtl/vproc_mem_arb_model_if.sv | 26 ++
 rtl/vproc_mem_arb_model.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/vproc_mem_arb_model_if.sv
// Request/response bundle between NUM_PORTS requesters and the arbitrated
// memory model. Every per-port field is a flat vector, indexed by port.
interface vproc_mem_arb_model_if #(
    parameter int NUM_PORTS = 2,
    parameter int MEM_W     = 32
);
    logic [NUM_PORTS-1:0]         req_i;
    logic [NUM_PORTS*32-1:0]      addr_i;
    logic [NUM_PORTS-1:0]         we_i;
    logic [NUM_PORTS*MEM_W/8-1:0] be_i;
    logic [NUM_PORTS*MEM_W-1:0]   wdata_i;
    logic [NUM_PORTS-1:0]         gnt_o;
    logic [NUM_PORTS-1:0]         rvalid_o;
    logic [NUM_PORTS-1:0]         err_o;
    logic [NUM_PORTS*MEM_W-1:0]   rdata_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, err_o, rdata_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        output gnt_o, rvalid_o, err_o, rdata_o
    );
endinterface

// File: rtl/vproc_mem_arb_model.sv
// Multi-requester memory model: round-robin arbiter in front of one
// single-ported word array, followed by a fixed-latency response pipeline
// whose entries carry the originating port so responses return in grant order.
// Optional random grant stalls: define MEM_STALL_INJECT_EN.
module vproc_mem_arb_model #(
    parameter int          NUM_PORTS   = 2,
    parameter int          MEM_W       = 32,
    parameter int          MEM_SZ      = 262144,
    parameter int          MEM_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter logic [31:0] END_ADDR    = 32'h0000_2000,
    parameter string       INIT_FILE   = "",
    parameter logic [15:0] STALL_SEED  = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst,
    vproc_mem_arb_model_if.slave   bus,
    output logic                   prog_end_o
);
    localparam int BYTES = MEM_W / 8;
    localparam int WORDS = MEM_SZ / BYTES;
    localparam int AW    = $clog2(MEM_SZ);
    localparam int LSB   = $clog2(BYTES);
    localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [MEM_W-1:0] mem [WORDS];

    logic [PW-1:0]    rr_ptr_reg;
    logic             prog_end_reg;
    logic             stall;
    logic             grant_any;
    logic [PW-1:0]    grant_port;
    logic [31:0]      sel_addr;
    logic             sel_we;
    logic [BYTES-1:0] sel_be;
    logic [MEM_W-1:0] sel_wdata;
    logic [31:0]      off;
    logic             sel_err;
    logic [AW-LSB-1:0] idx;
    logic [MEM_W-1:0] rd_word_reg;

    logic [MEM_LATENCY-1:0] pipe_valid_reg;
    logic [MEM_LATENCY-1:0] pipe_err_reg;
    logic [PW-1:0]          pipe_port_reg [MEM_LATENCY];
    logic                   rd0_reg;
    logic [MEM_W-1:0]       stage_data [MEM_LATENCY];

`ifdef MEM_STALL_INJECT_EN
    logic [15:0] lfsr_reg;

    // Fibonacci LFSR (taps 16,14,13,11); bit 0 set means this cycle is stalled
    always_ff @(posedge clk) begin
        if (rst) lfsr_reg <= STALL_SEED;
        else     lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end
    assign stall = lfsr_reg[0];
`else
    assign stall = 1'b0;
`endif

    // Round-robin pick: scan upward from the pointer, first requester wins
    always_comb begin
        grant_any  = 1'b0;
        grant_port = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!grant_any && bus.req_i[(int'(rr_ptr_reg) + i) % NUM_PORTS]) begin
                grant_any  = 1'b1;
                grant_port = PW'((int'(rr_ptr_reg) + i) % NUM_PORTS);
            end
        end
        if (stall) begin
            grant_any  = 1'b0;
            grant_port = '0;
        end
    end

    // One-hot grant plus the winning port's request fields and decoded address
    always_comb begin
        bus.gnt_o = '0;
        if (grant_any) bus.gnt_o[grant_port] = 1'b1;
        sel_addr  = bus.addr_i[int'(grant_port)*32 +: 32];
        sel_we    = bus.we_i[grant_port];
        sel_be    = bus.be_i[int'(grant_port)*BYTES +: BYTES];
        sel_wdata = bus.wdata_i[int'(grant_port)*MEM_W +: MEM_W];
        off       = sel_addr - BASE_ADDR;
        sel_err   = (off >= 32'(MEM_SZ));
        idx       = off[AW-1:LSB];
    end

    // Byte-masked write and registered read (read returns pre-write data)
    always_ff @(posedge clk) begin
        if (grant_any && sel_we && !sel_err) begin
            for (int b = 0; b < BYTES; b++) begin
                if (sel_be[b]) mem[idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
            end
        end
        rd_word_reg <= mem[idx];
    end

    // Response control pipeline: stage 0 loads on grant, then shifts each cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid_reg <= '0;
            pipe_err_reg   <= '0;
            rd0_reg        <= 1'b0;
            for (int k = 0; k < MEM_LATENCY; k++) pipe_port_reg[k] <= '0;
        end else begin
            pipe_valid_reg[0] <= grant_any;
            pipe_err_reg[0]   <= sel_err;
            pipe_port_reg[0]  <= grant_port;
            rd0_reg           <= !sel_we;
            for (int k = 1; k < MEM_LATENCY; k++) begin
                pipe_valid_reg[k] <= pipe_valid_reg[k-1];
                pipe_err_reg[k]   <= pipe_err_reg[k-1];
                pipe_port_reg[k]  <= pipe_port_reg[k-1];
            end
        end
    end

    // Stage 0 data is the RAM output itself; writes and errors return zero
    assign stage_data[0] = (rd0_reg && !pipe_err_reg[0]) ? rd_word_reg : '0;

    for (genvar gi = 1; gi < MEM_LATENCY; gi++) begin : g_stage
        logic [MEM_W-1:0] data_reg;
        // Data follows the control stages; validity comes from pipe_valid_reg
        always_ff @(posedge clk) begin
            data_reg <= stage_data[gi-1];
        end
        assign stage_data[gi] = data_reg;
    end

    // Route the last stage to its port; idle ports see zeros
    always_comb begin
        bus.rvalid_o = '0;
        bus.err_o    = '0;
        bus.rdata_o  = '0;
        if (pipe_valid_reg[MEM_LATENCY-1]) begin
            bus.rvalid_o[pipe_port_reg[MEM_LATENCY-1]] = 1'b1;
            bus.err_o[pipe_port_reg[MEM_LATENCY-1]]    = pipe_err_reg[MEM_LATENCY-1];
            bus.rdata_o[int'(pipe_port_reg[MEM_LATENCY-1])*MEM_W +: MEM_W] = stage_data[MEM_LATENCY-1];
        end
    end

    // Pointer advance past the winner, and program-end pulse one cycle after the grant
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg   <= '0;
            prog_end_reg <= 1'b0;
        end else begin
            if (grant_any)
                rr_ptr_reg <= (int'(grant_port) == NUM_PORTS - 1) ? '0 : grant_port + 1'b1;
            prog_end_reg <= grant_any && (sel_addr == END_ADDR);
        end
    end

    assign prog_end_o = prog_end_reg;
endmodule
